// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and defaults for the UART receive buffer.
// Holds the irq trigger-level encoding and a helper that maps it to an occupancy threshold.
package uart_pkg;

  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    TRIG_1   = 2'b00,
    TRIG_4   = 2'b01,
    TRIG_8   = 2'b10,
    TRIG_NM2 = 2'b11
  } trig_sel_e;

  function automatic int trigThreshold(trig_sel_e sel, int depth);
    case (sel)
      TRIG_1:  return 1;
      TRIG_4:  return 4;
      TRIG_8:  return 8;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bundle of receiver-side and register-block-side signals of the UART receive buffer.
// master = environment (receiver + APB block), slave = the buffer itself.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          fifo_clr_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          parity_err_i;
  logic          stop_err_i;
  logic          rts_no;
  logic          rd_en_i;
  logic [7:0]    rd_data_o;
  logic          empty_o;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic [1:0]    trig_sel_i;
  logic          rx_irq_o;
  logic          lsr_rd_i;
  logic          pe_o;
  logic          fe_o;
  logic          oe_o;

  modport master (
    output fifo_clr_i, rx_data_i, rx_valid_i, parity_err_i, stop_err_i,
           rd_en_i, trig_sel_i, lsr_rd_i,
    input  rts_no, rd_data_o, empty_o, full_o, level_o, rx_irq_o, pe_o, fe_o, oe_o
  );

  modport slave (
    input  fifo_clr_i, rx_data_i, rx_valid_i, parity_err_i, stop_err_i,
           rd_en_i, trig_sel_i, lsr_rd_i,
    output rts_no, rd_data_o, empty_o, full_o, level_o, rx_irq_o, pe_o, fe_o, oe_o
  );

endinterface

// File: rtl/uart_rx_fifo_sync.sv
// Generic first-word-fall-through synchronous FIFO with an explicit occupancy counter.
// A write while full is accepted only if a read frees a slot in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_clr,
  input  logic                       i_wrEn,
  input  logic [WIDTH-1:0]           i_wrData,
  input  logic                       i_rdEn,
  output logic [WIDTH-1:0]           o_rdData,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [$clog2(DEPTH):0]     o_levelNext
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic             w_wrOk;
  logic             w_rdOk;

  assign o_empty  = (r_level == '0);
  assign o_full   = (r_level == LW'(DEPTH));
  assign o_level  = r_level;
  assign o_rdData = o_empty ? '0 : r_mem[r_rdPtr];

  assign w_rdOk = i_rdEn && !o_empty;
  assign w_wrOk = i_wrEn && (!o_full || w_rdOk);

  // Post-update occupancy; the wrapper derives its flow-control state from it.
  always_comb begin
    o_levelNext = r_level;
    if (i_clr)
      o_levelNext = '0;
    else if (w_wrOk && !w_rdOk)
      o_levelNext = r_level + LW'(1);
    else if (!w_wrOk && w_rdOk)
      o_levelNext = r_level - LW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      r_level <= o_levelNext;
      if (i_clr) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
      end else begin
        if (w_wrOk)
          r_wrPtr <= r_wrPtr + AW'(1);
        if (w_rdOk)
          r_rdPtr <= r_rdPtr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wrOk && !i_clr)
      r_mem[r_wrPtr] <= i_wrData;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: FWFT storage plus overrun detection, sticky line-status flags,
// flow control with hysteresis toward the receiver, and the trigger-level interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int RTS_HI = 14,
  parameter int RTS_LO = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [LW-1:0] w_level;
  logic [LW-1:0] w_levelNext;
  logic          w_full;
  logic          w_overrun;
  logic          r_pe;
  logic          r_fe;
  logic          r_oe;
  logic          r_rts;

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_clr       (bus.fifo_clr_i),
    .i_wrEn      (bus.rx_valid_i),
    .i_wrData    (bus.rx_data_i),
    .i_rdEn      (bus.rd_en_i),
    .o_rdData    (bus.rd_data_o),
    .o_empty     (bus.empty_o),
    .o_full      (w_full),
    .o_level     (w_level),
    .o_levelNext (w_levelNext)
  );

  // A flush discards the concurrent character, so it is not counted as an overrun.
  assign w_overrun = bus.rx_valid_i && w_full && !bus.rd_en_i && !bus.fifo_clr_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pe  <= 1'b0;
      r_fe  <= 1'b0;
      r_oe  <= 1'b0;
      r_rts <= 1'b0;
    end else begin
      r_pe <= bus.parity_err_i || (r_pe && !bus.lsr_rd_i);
      r_fe <= bus.stop_err_i   || (r_fe && !bus.lsr_rd_i);
      r_oe <= w_overrun        || (r_oe && !bus.lsr_rd_i);
      if (int'(w_levelNext) >= RTS_HI)
        r_rts <= 1'b1;
      else if (int'(w_levelNext) <= RTS_LO)
        r_rts <= 1'b0;
    end
  end

  assign bus.full_o   = w_full;
  assign bus.level_o  = w_level;
  assign bus.rts_no   = r_rts;
  assign bus.pe_o     = r_pe;
  assign bus.fe_o     = r_fe;
  assign bus.oe_o     = r_oe;
  assign bus.rx_irq_o = int'(w_level) >= trigThreshold(trig_sel_e'(bus.trig_sel_i), DEPTH);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int RTS_HI = 14;
  localparam int RTS_LO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Model state: buffer contents, sticky flags and flow-control line.
  logic [7:0] q[$];
  bit mPe, mFe, mOe, mRts;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .RTS_HI (RTS_HI),
    .RTS_LO (RTS_LO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int mThr();
    case (bus.trig_sel_i)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return DEPTH - 2;
    endcase
  endfunction

  function automatic logic [7:0] mHead();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  // Drive one cycle of inputs, advance the model across the clock edge, settle outputs.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd,
                      input bit pe = 0, input bit fe = 0, input bit lsr = 0, input bit clr = 0);
    bit doRd, doWr, ovr;
    bus.rx_valid_i   = wr;
    bus.rx_data_i    = d;
    bus.rd_en_i      = rd;
    bus.parity_err_i = pe;
    bus.stop_err_i   = fe;
    bus.lsr_rd_i     = lsr;
    bus.fifo_clr_i   = clr;
    @(posedge clk);
    ovr = 0;
    if (clr) begin
      q.delete();
    end else begin
      doRd = rd && (q.size() > 0);
      doWr = wr && ((q.size() < DEPTH) || doRd);
      ovr  = wr && !doWr;
      if (doRd) void'(q.pop_front());
      if (doWr) q.push_back(d);
    end
    mPe = pe  || (mPe && !lsr);
    mFe = fe  || (mFe && !lsr);
    mOe = ovr || (mOe && !lsr);
    if (q.size() >= RTS_HI) mRts = 1;
    else if (q.size() <= RTS_LO) mRts = 0;
    #1;
    bus.rx_valid_i   = 0;
    bus.rd_en_i      = 0;
    bus.parity_err_i = 0;
    bus.stop_err_i   = 0;
    bus.lsr_rd_i     = 0;
    bus.fifo_clr_i   = 0;
  endtask

  task automatic test_reset();
    step(1, 8'hA1, 0);
    step(1, 8'hA2, 0);
    step(1, 8'hA3, 0, 1, 1);
    bus.rx_valid_i = 1;
    bus.rx_data_i  = 8'hA4;
    #2 reset_n = 0;
    #1;
    q.delete(); mPe = 0; mFe = 0; mOe = 0; mRts = 0;
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", bus.empty_o); end
    total++; if (bus.level_o !== 5'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", bus.level_o); end
    total++; if (bus.rts_no !== 1'b0) begin bad++; $display("[TB] FAIL reset_rts got=%b want=0", bus.rts_no); end
    total++; if (bus.rd_data_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata got=%h want=00", bus.rd_data_o); end
    total++; if ({bus.pe_o, bus.fe_o, bus.oe_o, bus.full_o, bus.rx_irq_o} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=00000", {bus.pe_o, bus.fe_o, bus.oe_o, bus.full_o, bus.rx_irq_o});
    end
    bus.rx_valid_i = 0;
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_order();
    logic [7:0] exp [3];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
    for (int i = 0; i < 3; i++) step(1, exp[i], 0);
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.rd_data_o !== exp[i]) begin bad++; $display("[TB] FAIL order_data%0d got=%h want=%h", i, bus.rd_data_o, exp[i]); end
      step(0, 8'h00, 1);
    end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("[TB] FAIL order_empty got=%b want=1", bus.empty_o); end
  endtask

  task automatic test_rts();
    for (int i = 0; i < 14; i++) begin
      step(1, 8'($urandom), 0);
      if (i == 12) begin
        total++; if (bus.rts_no !== 1'b0) begin bad++; $display("[TB] FAIL rts_at13 got=%b want=0", bus.rts_no); end
      end
    end
    total++; if (bus.rts_no !== 1'b1) begin bad++; $display("[TB] FAIL rts_at14 got=%b want=1", bus.rts_no); end
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        total++; if (bus.rts_no !== 1'b1) begin bad++; $display("[TB] FAIL rts_at9 got=%b want=1", bus.rts_no); end
      end
      step(0, 8'h00, 1);
    end
    total++; if (bus.level_o !== 5'd8) begin bad++; $display("[TB] FAIL rts_level got=%0d want=8", bus.level_o); end
    total++; if (bus.rts_no !== 1'b0) begin bad++; $display("[TB] FAIL rts_at8 got=%b want=0", bus.rts_no); end
  endtask

  task automatic test_overrun();
    logic [7:0] first;
    logic [7:0] got;
    step(0, 8'h00, 0, 0, 0, 1, 1);
    first = 8'($urandom);
    step(1, first, 0);
    for (int i = 1; i < DEPTH; i++) step(1, 8'($urandom), 0);
    step(1, 8'h55, 0);
    total++; if (bus.oe_o !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag got=%b want=1", bus.oe_o); end
    total++; if (bus.level_o !== 5'd16 || bus.full_o !== 1'b1) begin bad++; $display("[TB] FAIL ovr_level got=%0d want=16", bus.level_o); end
    total++; if (bus.rd_data_o !== first) begin bad++; $display("[TB] FAIL ovr_head got=%h want=%h", bus.rd_data_o, first); end
    step(0, 8'h00, 0, 0, 0, 1);
    step(1, 8'h55, 1);
    total++; if (bus.oe_o !== 1'b0) begin bad++; $display("[TB] FAIL full_wr_rd_oe got=%b want=0", bus.oe_o); end
    total++; if (bus.level_o !== 5'd16) begin bad++; $display("[TB] FAIL full_wr_rd_level got=%0d want=16", bus.level_o); end
    for (int i = 0; i < DEPTH; i++) begin
      got = bus.rd_data_o;
      total++; if (got !== q[0]) begin bad++; $display("[TB] FAIL drain%0d got=%h want=%h", i, got, q[0]); end
      step(0, 8'h00, 1);
    end
    total++; if (got !== 8'h55) begin bad++; $display("[TB] FAIL tail_55 got=%h want=55", got); end
  endtask

  task automatic test_sticky();
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 1, 0, 1);
    total++; if (bus.pe_o !== 1'b1) begin bad++; $display("[TB] FAIL pe_set_wins got=%b want=1", bus.pe_o); end
    step(0, 8'h00, 0, 0, 1, 0);
    total++; if (bus.fe_o !== 1'b1) begin bad++; $display("[TB] FAIL fe_set got=%b want=1", bus.fe_o); end
    step(0, 8'h00, 0, 0, 0, 1);
    total++; if ({bus.pe_o, bus.fe_o} !== 2'b00) begin bad++; $display("[TB] FAIL lsr_clear got=%b want=00", {bus.pe_o, bus.fe_o}); end
  endtask

  task automatic test_irq_clr();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0);
    bus.trig_sel_i = 2'b01; #1;
    total++; if (bus.rx_irq_o !== 1'b1) begin bad++; $display("[TB] FAIL irq_trig4 got=%b want=1", bus.rx_irq_o); end
    bus.trig_sel_i = 2'b10; #1;
    total++; if (bus.rx_irq_o !== 1'b0) begin bad++; $display("[TB] FAIL irq_trig8 got=%b want=0", bus.rx_irq_o); end
    bus.trig_sel_i = 2'b01;
    step(0, 8'h00, 0, 1, 1);
    step(1, 8'h77, 1, 0, 0, 0, 1);
    total++; if (bus.level_o !== 5'd0 || bus.empty_o !== 1'b1) begin bad++; $display("[TB] FAIL clr_level got=%0d want=0", bus.level_o); end
    total++; if (bus.rx_irq_o !== 1'b0) begin bad++; $display("[TB] FAIL clr_irq got=%b want=0", bus.rx_irq_o); end
    total++; if ({bus.pe_o, bus.fe_o} !== 2'b11) begin bad++; $display("[TB] FAIL clr_keeps_flags got=%b want=11", {bus.pe_o, bus.fe_o}); end
    for (int i = 0; i < 12; i++) step(1, 8'(i), 0);
    for (int i = 0; i < 12; i++) step(0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step(1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < 10; i++) begin
      total++; if (bus.rd_data_o !== 8'(8'hC0 + i)) begin bad++; $display("[TB] FAIL wrap%0d got=%h want=%h", i, bus.rd_data_o, 8'(8'hC0 + i)); end
      step(0, 8'h00, 1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.trig_sel_i = 2'($urandom_range(0, 3));
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);
      total++; if (bus.level_o !== 5'(q.size())) begin bad++; $display("[TB] FAIL rnd_level@%0d got=%0d want=%0d", n, bus.level_o, q.size()); end
      total++; if (bus.rd_data_o !== mHead()) begin bad++; $display("[TB] FAIL rnd_data@%0d got=%h want=%h", n, bus.rd_data_o, mHead()); end
      total++; if ({bus.empty_o, bus.full_o} !== {q.size() == 0, q.size() == DEPTH}) begin
        bad++; $display("[TB] FAIL rnd_empty_full@%0d got=%b%b want=%b%b", n, bus.empty_o, bus.full_o, q.size() == 0, q.size() == DEPTH);
      end
      total++; if (bus.rts_no !== mRts) begin bad++; $display("[TB] FAIL rnd_rts@%0d got=%b want=%b", n, bus.rts_no, mRts); end
      total++; if (bus.rx_irq_o !== (q.size() >= mThr())) begin bad++; $display("[TB] FAIL rnd_irq@%0d got=%b want=%b", n, bus.rx_irq_o, q.size() >= mThr()); end
      total++; if ({bus.pe_o, bus.fe_o, bus.oe_o} !== {mPe, mFe, mOe}) begin
        bad++; $display("[TB] FAIL rnd_flags@%0d got=%b%b%b want=%b%b%b", n, bus.pe_o, bus.fe_o, bus.oe_o, mPe, mFe, mOe);
      end
    end
  endtask

  initial begin
    bus.fifo_clr_i = 0; bus.rx_data_i = 0; bus.rx_valid_i = 0; bus.parity_err_i = 0;
    bus.stop_err_i = 0; bus.rd_en_i = 0; bus.trig_sel_i = 2'b00; bus.lsr_rd_i = 0;
    mPe = 0; mFe = 0; mOe = 0; mRts = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_order();
    test_rts();
    test_overrun();
    test_sticky();
    test_irq_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
